// File: rtl/clint_pkg.sv
// Shared definitions for the Wishbone CLINT.
//   - Register offsets within the 2 KiB CLINT window (byte offsets, adr[10:0]).
//   - clint_time_t: 64-bit machine time / compare value.
//   - clint_reg_e: decoded register class of a bus access.
//   - merge_lanes: applies Wishbone byte enables to one 32-bit half.
package clint_pkg;

  localparam logic [10:0] MSIP_OFF     = 11'h000;
  localparam logic [10:0] MTIMECMP_OFF = 11'h400;
  localparam logic [10:0] MTIME_LO_OFF = 11'h7F8;
  localparam logic [10:0] MTIME_HI_OFF = 11'h7FC;
  localparam int          MAX_HARTS    = 16;

  typedef logic [63:0] clint_time_t;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } clint_reg_e;

  // Byte lanes with a set enable take the new data, others keep the base value.
  function automatic logic [31:0] merge_lanes(input logic [31:0] base,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sel);
    logic [31:0] result;
    for (int b = 0; b < 4; b++) begin
      result[8*b +: 8] = sel[b] ? wdata[8*b +: 8] : base[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/clint_tick_div.sv
// mtime prescaler: produces a one-clock tick every TICK_DIV clocks.
// Ports:
//   clk    in  clock
//   rst    in  asynchronous active-high reset (counter restarts at 0)
//   tick_o out high in the clock where mtime must advance
module clint_tick_div #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  generate
    if (TICK_DIV <= 1) begin : g_every_clock
      // No counter needed: time advances on every clock.
      logic unused_inputs;
      assign unused_inputs = clk ^ rst;
      assign tick_o = 1'b1;
    end else begin : g_counter
      localparam int CW = $clog2(TICK_DIV);
      logic [CW-1:0] count;

      assign tick_o = (count == CW'(TICK_DIV - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count <= '0;
        end else if (tick_o) begin
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/clint_wb_multi.sv
// Wishbone B4 classic CLINT for NUM_HARTS harts: shared 64-bit mtime,
// per-hart mtimecmp with registered mtip, optional per-hart msip.
// Optional feature macro: CLINT_MSIP_EN (msip registers implemented when defined).
// Ports:
//   wb_clk_i, wb_rst_i       clock, async active-high reset
//   wb_cyc_i, wb_stb_i       bus cycle / strobe
//   wb_we_i, wb_sel_i        write enable, byte enables
//   wb_adr_i, wb_dat_i       byte address (adr[10:2] decoded), write data
//   wb_dat_o, wb_ack_o       registered read data, single-cycle ack
//   mtip_o, msip_o           per-hart timer / software interrupt pending
module clint_wb_multi
  import clint_pkg::*;
#(
  parameter int NUM_HARTS = 1,
  parameter int TICK_DIV  = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [3:0]           wb_sel_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic [NUM_HARTS-1:0] mtip_o,
  output logic [NUM_HARTS-1:0] msip_o
);

  localparam int HART_W = $clog2(MAX_HARTS);

  clint_time_t       mtime;
  clint_time_t       mtime_inc;
  clint_time_t       mtime_nxt;
  clint_time_t       mtimecmp [NUM_HARTS];
  clint_time_t       hart_cmp;
  clint_reg_e        kind;
  logic [HART_W-1:0] hart;
  logic [8:0]        word;
  logic [31:0]       rd_data;
  logic              acc;
  logic              wr;
  logic              tick;
  logic              msip_rd;
  logic              unused_adr;

  // The interconnect decodes the base; byte offset within a word is irrelevant.
  assign word       = wb_adr_i[10:2];
  assign unused_adr = ^{wb_adr_i[31:11], wb_adr_i[1:0]};

  // Suppressing the access while ack is high yields one ack per two cycles on a held strobe.
  assign acc = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr  = acc & wb_we_i;

  clint_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .tick_o (tick)
  );

  // Address decode; per-hart registers beyond NUM_HARTS fall back to unmapped.
  always_comb begin
    kind = REG_NONE;
    hart = '0;
    if (word[8:4] == MSIP_OFF[10:6]) begin
      kind = REG_MSIP;
      hart = word[3:0];
    end else if (word[8:5] == MTIMECMP_OFF[10:7]) begin
      kind = word[0] ? REG_CMP_HI : REG_CMP_LO;
      hart = word[4:1];
    end else if (word == MTIME_LO_OFF[10:2]) begin
      kind = REG_TIME_LO;
    end else if (word == MTIME_HI_OFF[10:2]) begin
      kind = REG_TIME_HI;
    end
    if ((kind == REG_MSIP || kind == REG_CMP_LO || kind == REG_CMP_HI) &&
        int'(hart) >= NUM_HARTS) begin
      kind = REG_NONE;
    end
  end

  always_comb begin
    hart_cmp = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hart == HART_W'(h)) hart_cmp = mtimecmp[h];
    end
  end

  // A write to one mtime half overrides only its enabled lanes of the
  // already-incremented value, so the tick and carry are never lost.
  always_comb begin
    mtime_inc = mtime + {63'b0, tick};
    mtime_nxt = mtime_inc;
    if (wr && kind == REG_TIME_LO) begin
      mtime_nxt[31:0] = merge_lanes(mtime_inc[31:0], wb_dat_i, wb_sel_i);
    end else if (wr && kind == REG_TIME_HI) begin
      mtime_nxt[63:32] = merge_lanes(mtime_inc[63:32], wb_dat_i, wb_sel_i);
    end
  end

  always_comb begin
    rd_data = '0;
    case (kind)
      REG_MSIP:    rd_data = {31'b0, msip_rd};
      REG_CMP_LO:  rd_data = hart_cmp[31:0];
      REG_CMP_HI:  rd_data = hart_cmp[63:32];
      REG_TIME_LO: rd_data = mtime[31:0];
      REG_TIME_HI: rd_data = mtime[63:32];
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= acc;
      if (acc) wb_dat_o <= rd_data;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mtime <= '0;
    end else begin
      mtime <= mtime_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else if (wr) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (hart == HART_W'(h)) begin
          if (kind == REG_CMP_LO) begin
            mtimecmp[h][31:0] <= merge_lanes(mtimecmp[h][31:0], wb_dat_i, wb_sel_i);
          end else if (kind == REG_CMP_HI) begin
            mtimecmp[h][63:32] <= merge_lanes(mtimecmp[h][63:32], wb_dat_i, wb_sel_i);
          end
        end
      end
    end
  end

  // Compare uses the current register values, hence one cycle behind any write.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mtip_o <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) mtip_o[h] <= (mtime >= mtimecmp[h]);
    end
  end

`ifdef CLINT_MSIP_EN
  logic [NUM_HARTS-1:0] msip;

  always_comb begin
    msip_rd = 1'b0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hart == HART_W'(h)) msip_rd = msip[h];
    end
  end

  // Only bit 0 is architected, so only lane 0 matters.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      msip <= '0;
    end else if (wr && kind == REG_MSIP && wb_sel_i[0]) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (hart == HART_W'(h)) msip[h] <= wb_dat_i[0];
      end
    end
  end

  assign msip_o = msip;
`else
  assign msip_rd = 1'b0;
  assign msip_o  = '0;
`endif

endmodule
